exec_stage: RTL and testbench
=============================

# exec_stage

Parametrised stage-3 execute unit. Combines the ALU, the shifter bypass mux and the result register, and adds four things:
- a configurable datapath width;
- a valid/ready input handshake;
- a multi-cycle shift-add multiply;
- a registered status-flag set (zero, negative, carry, overflow).

It sits between operand fetch/shift (stage 2) and write-back, and owns the result register that write-back reads.

## Interface
- WIDTH, 16, datapath width in bits (≥ 4).
- CLK  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- InValid  in  1  operation presented this cycle.
- InReady  out  1  unit can accept an operation this cycle.
- ALUInA  in  WIDTH  operand A.
- ALUInB  in  WIDTH  operand B.
- ShifterOut  in  WIDTH  shifter result (bypass source).
- ALUop  in  4  operation select.
- ResSource  in  1  0 = ALU result, 1 = ShifterOut.
- ResWrite  in  1  1 = commit result and flags; 0 = discard.
- ResOut  out  WIDTH  result register.
- OutValid  out  1  one-cycle pulse on the cycle after ResOut is updated.
- isZero  out  1  combinational (ResOut == 0).
- isNeg  out  1  combinational ResOut[WIDTH-1].
- Carry  out  1  registered carry flag.
- Overflow  out  1  registered signed-overflow flag.
- Busy  out  1  multiply in progress.

## Operation
- Accept: an operation is accepted at a rising edge where InValid && InReady. All inputs, including ResSource and ResWrite, are sampled at that edge.
- InReady = (state == IDLE).
- ALUop encoding:
  - 0 AND, 1 OR, 2 ADD, 3 SUB (A−B), 4 XOR, 5 NOR.
  - 6 SLT: signed A<B gives 1, else 0.
  - 7 SLTU: unsigned A<B gives 1, else 0.
  - 8 MUL: low WIDTH bits of A×B.
  - 9–15 reserved: result 0.
- Flags:
  - ADD: Carry = carry-out of bit WIDTH-1.
  - SUB: Carry = 1 when A ≥ B unsigned (no borrow).
  - Overflow = signed overflow for ADD/SUB.
  - All other ops, and any ResSource=1 op: Carry = 0, Overflow = 0.
- ResSource=1: single-cycle regardless of ALUop; ResOut ← ShifterOut.
- ResWrite=0: ResOut, Carry and Overflow hold; OutValid stays 0. A MUL with ResWrite=0 still runs its full sequence, then discards the result.
- State machine IDLE / MUL:
  - IDLE → MUL on accepting ALUop=8 with ResSource=0. Latch multiplicand = A, multiplier = B, accumulator = 0, counter = 0.
  - MUL, each cycle: if multiplier[0], accumulator += multiplicand (mod 2^WIDTH). Then multiplicand <<= 1, multiplier >>= 1, counter++.
  - MUL → IDLE at the edge where counter reaches WIDTH. If ResWrite was set, ResOut ← accumulator at that edge.
  - ALUInA/B changes during MUL have no effect.
- InValid while Busy: ignored. The source holds the operation until InReady.
- Reset at any time, including mid-MUL:
  - state IDLE; ResOut 0 (so isZero 1, isNeg 0);
  - Carry 0, Overflow 0, OutValid 0, Busy 0, InReady 1;
  - the partial product is discarded.

## Timing
- Single-cycle ops: accepted at edge N; ResOut and flags are valid after edge N. OutValid is high for the cycle following edge N. InReady stays 1, so an accept is possible at every edge.
- MUL: accepted at edge N. Busy = 1 and InReady = 0 from edge N until edge N+WIDTH. ResOut is written at edge N+WIDTH. OutValid is high for the following cycle. The next accept is possible at edge N+WIDTH+1.
- isZero and isNeg track ResOut combinationally, with no extra latency.
- Reset deasserted: the first accept can occur at the next rising edge.

## Test plan
- AND sweep, i = 0..99: ALUInA = 5i, ALUInB = 0xFFFF − 3i, ALUop = 0, ResWrite = 1. Required: after each edge ResOut = A & B, OutValid pulses, InReady stays 1.
- ADD 0xFFFF + 0x0001 → ResOut 0x0000, isZero 1, Carry 1, Overflow 0. ADD 0x7FFF + 0x0001 → 0x8000, isNeg 1, Overflow 1. SUB 0x0003 − 0x0005 → 0xFFFE, Carry 0.
- MUL 0x0012 × 0x0034 → ResOut 0x03A8 exactly 16 edges after accept. Required: InReady 0 and Busy 1 for 16 cycles, a single OutValid pulse, and a held second request accepted at edge 17.
- ResWrite = 0 after ResOut = 0x1234: ADD 1+1 → ResOut stays 0x1234, no OutValid. ResSource = 1, ShifterOut = 0xA5A5, ALUop = 8 → ResOut 0xA5A5 after 1 edge, Busy never 1.
- Reset pulsed 5 cycles into MUL 0x00FF × 0x00FF → ResOut 0, isZero 1, InReady 1 immediately. A following AND 0x0F0F & 0x00FF → 0x000F.
- WIDTH = 8 instance: ADD 0xFF + 0x01 → 0x00, Carry 1. MUL 0x0F × 0x11 → 0xFF after 8 edges.

Source files
------------

// File: rtl/exec_stage.sv
// Execute stage: ALU, shifter bypass, shift-add multiplier and the result/flag registers
// that write-back reads. Single-cycle ops commit on accept; MUL iterates WIDTH cycles.
module exec_stage #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] ALUInA,
  input  logic [WIDTH-1:0] ALUInB,
  input  logic [WIDTH-1:0] ShifterOut,
  input  logic [3:0]       ALUop,
  input  logic             ResSource,
  input  logic             ResWrite,
  output logic [WIDTH-1:0] ResOut,
  output logic             OutValid,
  output logic             isZero,
  output logic             isNeg,
  output logic             Carry,
  output logic             Overflow,
  output logic             Busy
);

  localparam int CW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_nxt;
  logic             accept, mul_start, mul_last, mul_wr;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_step;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  assign InReady   = (state == IDLE);
  assign Busy      = (state == MUL);
  assign accept    = InValid && InReady;
  assign mul_start = accept && !ResSource && (ALUop == 4'd8);
  assign mul_last  = (state == MUL) && (cnt == CW'(WIDTH - 1));
  assign isZero    = (ResOut == '0);
  assign isNeg     = ResOut[MSB];

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mul_start) state_nxt = MUL;
      MUL:     if (mul_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sum  = {1'b0, ALUInA} + {1'b0, ALUInB};
  assign diff = {1'b0, ALUInA} - {1'b0, ALUInB};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUop)
      4'd0: alu_res = ALUInA & ALUInB;
      4'd1: alu_res = ALUInA | ALUInB;
      4'd2: begin
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (ALUInA[MSB] == ALUInB[MSB]) && (sum[MSB] != ALUInA[MSB]);
      end
      4'd3: begin
        alu_res = diff[MSB:0];
        alu_c   = ~diff[WIDTH];
        alu_v   = (ALUInA[MSB] != ALUInB[MSB]) && (diff[MSB] != ALUInA[MSB]);
      end
      4'd4: alu_res = ALUInA ^ ALUInB;
      4'd5: alu_res = ~(ALUInA | ALUInB);
      4'd6: alu_res = {{(WIDTH-1){1'b0}}, ($signed(ALUInA) < $signed(ALUInB))};
      4'd7: alu_res = {{(WIDTH-1){1'b0}}, (ALUInA < ALUInB)};
      default: alu_res = '0;
    endcase
  end

  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ResOut   <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
      OutValid <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      mul_wr   <= 1'b0;
    end else begin
      OutValid <= 1'b0;
      if (accept) begin
        if (mul_start) begin
          mcand  <= ALUInA;
          mplier <= ALUInB;
          acc    <= '0;
          cnt    <= '0;
          mul_wr <= ResWrite;
        end else if (ResWrite) begin
          ResOut   <= ResSource ? ShifterOut : alu_res;
          Carry    <= !ResSource && alu_c;
          Overflow <= !ResSource && alu_v;
          OutValid <= 1'b1;
        end
      end else if (state == MUL) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        // final step's sum goes straight to the result register
        if (mul_last && mul_wr) begin
          ResOut   <= acc_step;
          Carry    <= 1'b0;
          Overflow <= 1'b0;
          OutValid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: transaction-level model checked every cycle (WIDTH=16) plus
// directed literal checks, and a WIDTH=8 instance with literal checks.
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] alu_a = '0, alu_b = '0, shifter = '0, res_out;
  logic [3:0]  alu_op = '0;
  logic        res_src = 1'b0, res_wr = 1'b0;
  logic        out_valid, is_zero, is_neg, carry, overflow, busy;

  logic        b_valid = 1'b0, b_ready;
  logic [7:0]  b_a = '0, b_b = '0, b_sh = '0, b_res;
  logic [3:0]  b_op = '0;
  logic        b_src = 1'b0, b_wr = 1'b0;
  logic        b_ov, b_zero, b_neg, b_carry, b_ovf, b_busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  exec_stage #(.WIDTH(16)) u16 (
    .CLK(clk), .Reset(rst), .InValid(in_valid), .InReady(in_ready),
    .ALUInA(alu_a), .ALUInB(alu_b), .ShifterOut(shifter), .ALUop(alu_op),
    .ResSource(res_src), .ResWrite(res_wr), .ResOut(res_out), .OutValid(out_valid),
    .isZero(is_zero), .isNeg(is_neg), .Carry(carry), .Overflow(overflow), .Busy(busy)
  );

  exec_stage #(.WIDTH(8)) u8 (
    .CLK(clk), .Reset(rst), .InValid(b_valid), .InReady(b_ready),
    .ALUInA(b_a), .ALUInB(b_b), .ShifterOut(b_sh), .ALUop(b_op),
    .ResSource(b_src), .ResWrite(b_wr), .ResOut(b_res), .OutValid(b_ov),
    .isZero(b_zero), .isNeg(b_neg), .Carry(b_carry), .Overflow(b_ovf), .Busy(b_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic void golden(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic c, output logic v);
    int ua = a;
    int ub = b;
    int sa = $signed(a);
    int sb = $signed(b);
    int t = 0;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin t = ua + ub; r = t[15:0]; c = (t > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
      4'd3: begin t = ua - ub; r = t[15:0]; c = (ua >= ub);  v = (sa - sb > 32767) || (sa - sb < -32768); end
      4'd4: r = a ^ b;
      4'd5: r = ~(a | b);
      4'd6: r = (sa < sb) ? 16'd1 : 16'd0;
      4'd7: r = (ua < ub) ? 16'd1 : 16'd0;
      4'd8: begin t = ua * ub; r = t[15:0]; end
      default: r = '0;
    endcase
  endfunction

  // Transaction model of the 16-bit unit.
  int          busy_left;
  logic [15:0] m_res, pend;
  logic        m_c, m_v, m_ov, pend_wr;

  always @(posedge clk or posedge rst) begin
    logic [15:0] r;
    logic        c, v;
    if (rst) begin
      busy_left = 0; m_res = '0; m_c = 1'b0; m_v = 1'b0; m_ov = 1'b0; pend = '0; pend_wr = 1'b0;
    end else begin
      m_ov = 1'b0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0 && pend_wr) begin
          m_res = pend; m_c = 1'b0; m_v = 1'b0; m_ov = 1'b1;
        end
      end else if (in_valid) begin
        golden(alu_op, alu_a, alu_b, r, c, v);
        if (!res_src && alu_op == 4'd8) begin
          pend = r; pend_wr = res_wr; busy_left = 16;
        end else if (res_wr) begin
          m_res = res_src ? shifter : r;
          m_c   = res_src ? 1'b0 : c;
          m_v   = res_src ? 1'b0 : v;
          m_ov  = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("res_out",   res_out,   m_res);
    chk("carry",     carry,     m_c);
    chk("overflow",  overflow,  m_v);
    chk("out_valid", out_valid, m_ov);
    chk("in_ready",  in_ready,  busy_left == 0);
    chk("busy",      busy,      busy_left > 0);
    chk("is_zero",   is_zero,   m_res == 16'h0);
    chk("is_neg",    is_neg,    m_res[15]);
  end

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic src, input logic [15:0] sh, input logic wr);
    @(negedge clk);
    in_valid = 1'b1; alu_op = op; alu_a = a; alu_b = b; res_src = src; shifter = sh; res_wr = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle16();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    b_valid = 1'b1; b_op = op; b_a = a; b_b = b; b_src = 1'b0; b_wr = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] gr;
    logic        gc, gv;
    int          ov_cnt;

    golden(4'd2, 16'hFFFF, 16'h0001, gr, gc, gv);
    chk("model_add_wrap", {gr, 7'd0, gc, 7'd0, gv}, {16'h0000, 8'h01, 8'h00});
    golden(4'd3, 16'h8000, 16'h0001, gr, gc, gv);
    chk("model_sub_ovf", {gr, 7'd0, gc, 7'd0, gv}, {16'h7FFF, 8'h01, 8'h01});
    golden(4'd6, 16'hFFFF, 16'h0001, gr, gc, gv);
    chk("model_slt", gr, 16'h0001);
    golden(4'd8, 16'h0012, 16'h0034, gr, gc, gv);
    chk("model_mul", gr, 16'h03A8);

    repeat (2) @(negedge clk);
    chk("rst_res", res_out, 16'h0);
    chk("rst_zero", is_zero, 1'b1);
    chk("rst_ready", in_ready, 1'b1);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      issue(4'd0, 16'(5 * i), 16'(16'hFFFF - 3 * i), 1'b0, 16'h0, 1'b1);
      chk("and_sweep", res_out, 16'(5 * i) & 16'(16'hFFFF - 3 * i));
    end

    issue(4'd2, 16'hFFFF, 16'h0001, 1'b0, 16'h0, 1'b1);
    chk("add_wrap_res", res_out, 16'h0000);
    chk("add_wrap_zero", is_zero, 1'b1);
    chk("add_wrap_c", carry, 1'b1);
    chk("add_wrap_v", overflow, 1'b0);
    issue(4'd2, 16'h7FFF, 16'h0001, 1'b0, 16'h0, 1'b1);
    chk("add_ovf_res", res_out, 16'h8000);
    chk("add_ovf_neg", is_neg, 1'b1);
    chk("add_ovf_v", overflow, 1'b1);
    issue(4'd3, 16'h0003, 16'h0005, 1'b0, 16'h0, 1'b1);
    chk("sub_res", res_out, 16'hFFFE);
    chk("sub_c", carry, 1'b0);
    issue(4'd6, 16'h8000, 16'h0001, 1'b0, 16'h0, 1'b1);
    chk("slt", res_out, 16'h0001);
    issue(4'd7, 16'h8000, 16'h0001, 1'b0, 16'h0, 1'b1);
    issue(4'd4, 16'hF0F0, 16'h3C3C, 1'b0, 16'h0, 1'b1);
    issue(4'd5, 16'hF0F0, 16'h0303, 1'b0, 16'h0, 1'b1);
    issue(4'd1, 16'h1200, 16'h0034, 1'b0, 16'h0, 1'b1);
    issue(4'd12, 16'h1234, 16'h5678, 1'b0, 16'h0, 1'b1);
    chk("reserved", res_out, 16'h0000);
    issue(4'd3, 16'h8000, 16'h0001, 1'b0, 16'h0, 1'b1);

    // MUL with a second request held on the inputs while busy
    issue(4'd8, 16'h0012, 16'h0034, 1'b0, 16'h0, 1'b1);
    chk("mul_busy", busy, 1'b1);
    chk("mul_not_ready", in_ready, 1'b0);
    @(negedge clk);
    alu_op = 4'd0; alu_a = 16'hF0F0; alu_b = 16'h0FF0;
    ov_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      ov_cnt += int'(out_valid);
    end
    chk("mul_res", res_out, 16'h03A8);
    chk("mul_ov_pulses", ov_cnt, 1);
    chk("mul_ready_after", in_ready, 1'b1);
    @(posedge clk);
    #1;
    chk("held_req", res_out, 16'h00F0);
    idle16();

    issue(4'd1, 16'h1200, 16'h0034, 1'b0, 16'h0, 1'b1);
    chk("preload", res_out, 16'h1234);
    issue(4'd2, 16'h0001, 16'h0001, 1'b0, 16'h0, 1'b0);
    chk("nowrite_hold", res_out, 16'h1234);
    chk("nowrite_ov", out_valid, 1'b0);
    issue(4'd8, 16'h0007, 16'h0009, 1'b1, 16'hA5A5, 1'b1);
    chk("bypass_res", res_out, 16'hA5A5);
    chk("bypass_busy", busy, 1'b0);
    issue(4'd8, 16'h0003, 16'h0003, 1'b0, 16'h0, 1'b0);
    idle16();
    repeat (18) @(negedge clk);
    chk("mul_nowrite", res_out, 16'hA5A5);

    issue(4'd8, 16'h00FF, 16'h00FF, 1'b0, 16'h0, 1'b1);
    idle16();
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midmul_rst_res", res_out, 16'h0);
    chk("midmul_rst_zero", is_zero, 1'b1);
    chk("midmul_rst_ready", in_ready, 1'b1);
    chk("midmul_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    issue(4'd0, 16'h0F0F, 16'h00FF, 1'b0, 16'h0, 1'b1);
    chk("post_rst_and", res_out, 16'h000F);
    idle16();

    issue8(4'd2, 8'hFF, 8'h01);
    chk("w8_add_res", b_res, 8'h00);
    chk("w8_add_c", b_carry, 1'b1);
    chk("w8_add_zero", b_zero, 1'b1);
    @(negedge clk);
    b_valid = 1'b1; b_op = 4'd8; b_a = 8'h0F; b_b = 8'h11; b_src = 1'b0; b_wr = 1'b1;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k < 8) chk("w8_mul_busy", b_busy, 1'b1);
      @(posedge clk);
      #1;
    end
    chk("w8_mul_res", b_res, 8'hFF);
    chk("w8_mul_ov", b_ov, 1'b1);
    chk("w8_mul_idle", b_busy, 1'b0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
